pe_feeder: RTL and testbench
============================

Name: pe_feeder

Overview:
- Hardware initiator that drives one pe processing element with a programmed sequence of signed operand pairs and collects the results.
- Each pair is issued as a single-cycle pe valid pulse. The feeder waits for pe done to rise, captures y_out/overflow, waits for done to fall, inserts a programmable idle gap, then issues the next pair.
- It replaces the software stimulus loop and is the front end a systolic-array controller uses per PE.

Parameters:
- DATA_W, 8, operand width (signed).
- ACC_W, 32, pe result width (signed).
- DEPTH, 8, operand-pair buffer entries (power of 2).
- GAP_W, 8, width of the inter-operation gap counter.
- TIMEOUT, 255, maximum cycles to wait for each done edge before aborting.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write one operand pair into buffer
- wr_a  in  DATA_W  signed operand A
- wr_b  in  DATA_W  signed operand B
- wr_full  out  1  buffer holds DEPTH pairs
- start  in  1  begin sequence (pulse)
- count  in  $clog2(DEPTH)+1  pairs to issue, sampled at start
- gap  in  GAP_W  idle cycles after done falls, sampled at start
- busy  out  1  sequence in progress
- pe_valid  out  1  to pe valid
- pe_a  out  DATA_W  to pe A_in
- pe_b  out  DATA_W  to pe B_in
- pe_y  in  ACC_W  from pe y_out
- pe_ovf  in  1  from pe overflow
- pe_done  in  1  from pe done
- res  out  ACC_W  captured result
- res_ovf  out  1  captured overflow
- res_valid  out  1  one-cycle pulse per captured result
- ovf_sticky  out  1  OR of all overflows this sequence
- finished  out  1  one-cycle pulse at sequence end
- timeout_err  out  1  set on timeout abort, cleared by next start

Behaviour:
- Reset: all outputs 0; buffer write pointer 0; FSM in IDLE. Reset mid-sequence aborts the sequence and clears the buffer.
- Buffer: writes are accepted only in IDLE with wr_full=0. wr_en is ignored while busy or full. wr_full = (wr_ptr==DEPTH).
- The buffer is cleared (wr_ptr to 0) on finished and on timeout abort.
- start is accepted in IDLE only; it is ignored while busy.
- count is clamped to wr_ptr. If the effective count is 0, finished pulses on the next cycle and busy stays 0.
- FSM states: IDLE, ARM, ISSUE, WAIT_HI, CAPTURE, WAIT_LO, GAP, DONE.
- IDLE: on start with count>0, go to ARM; busy=1; idx=0; ovf_sticky=0; timeout_err=0.
- ARM: wait until pe_done=0, then go to ISSUE. This guards against a stale done.
- ISSUE: pe_a/pe_b = buffer[idx]; pe_valid=1 for exactly this cycle. Go to WAIT_HI. Operands are held until the next ISSUE.
- Start latency: start sampled at cycle N gives ARM at N+1 and pe_valid high at N+2 at the earliest.
- WAIT_HI: on pe_done=1, go to CAPTURE.
- CAPTURE: res<=pe_y; res_ovf<=pe_ovf; ovf_sticky|=pe_ovf. res_valid pulses the cycle after CAPTURE, and res/res_ovf hold until the next capture. Go to WAIT_LO.
- WAIT_LO: on pe_done=0, go to GAP with gap counter loaded.
- GAP: decrement the counter. When it reaches 0 (or gap==0 on entry), idx++. If idx==count go to DONE, else ISSUE.
- DONE: finished=1 for one cycle; busy=0; go to IDLE.
- Timeout: one counter covers ARM, WAIT_HI and WAIT_LO. It is reset on each state entry.
  - If it reaches TIMEOUT, set timeout_err=1, pulse finished, set busy=0, clear the buffer and go to IDLE.
  - No res_valid is produced for the aborted pair.
- pe_done high in the same cycle as ISSUE is not treated as completion; WAIT_HI samples from the next cycle.
- All arithmetic is pass-through. Signed values are not extended or modified.

Decomposition:
- Package pe_pkg holds DATA_W, ACC_W, and the typedef feeder_state_t (enum above).
- Sub-module pe_feeder_buf holds the DEPTH x 2*DATA_W register file with write pointer, full flag and clear.
- The FSM, counters and result registers stay in the top module.

Test Plan:
- Load 4 pairs (10,2), (-20,3), (30,-4), (-40,5); start with count=4, gap=3, driving an accumulating pe -> four res_valid pulses with res = 20, -40, -160, -360; ovf_sticky=0; finished once.
- wr_en for 9 pairs with DEPTH=8 -> wr_full=1 after the 8th write; the 9th is dropped; count=9 is clamped to 8, giving 8 pe_valid pulses.
- start with an empty buffer or count=0 -> finished the cycle after start; pe_valid never asserts; busy stays 0.
- pe model with done stuck low -> timeout_err=1 and finished after TIMEOUT+1 cycles in WAIT_HI; busy=0; a following start clears timeout_err.
- pe_done held high at start -> pe_valid is withheld until done falls; then normal issue.
- Assert reset during the WAIT_HI of pair 2 -> the next cycle shows all outputs 0, wr_full=0 and an IDLE state; a subsequent start with count=1 and no new load finishes immediately.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared widths and FSM state encoding for the pe_feeder slice.
package pe_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_CAPTURE = 3'd4,
        S_WAIT_LO = 3'd5,
        S_GAP     = 3'd6,
        S_DONE    = 3'd7
    } feeder_state_t;
endpackage

// File: rtl/pe_feeder_buf.sv
// Operand-pair register file: sequential write pointer, full flag, clear, async read by index.
module pe_feeder_buf
    import pe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_a,
    input  logic [DATA_W-1:0]        i_wr_b,
    input  logic                     i_clear,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [DATA_W-1:0]        o_rd_a,
    output logic [DATA_W-1:0]        o_rd_b,
    output logic [$clog2(DEPTH):0]   o_wr_ptr,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_PTR = PW'(DEPTH);

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic                w_push;

    assign o_full   = (r_wr_ptr == FULL_PTR);
    assign w_push   = i_wr_en && !o_full && !i_clear;
    assign o_wr_ptr = r_wr_ptr;
    assign {o_rd_a, o_rd_b} = r_mem[i_rd_idx];

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries beyond the pointer are never issued.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_wr_a, i_wr_b};
        end
    end
endmodule

// File: rtl/pe_feeder.sv
// Sequencer that issues buffered operand pairs to one pe, one valid pulse per pair,
// and captures each result with a shared per-wait timeout.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_a,
    input  logic [DATA_W-1:0]      wr_b,
    output logic                   wr_full,
    input  logic                   start,
    input  logic [$clog2(DEPTH):0] count,
    input  logic [GAP_W-1:0]       gap,
    output logic                   busy,
    output logic                   pe_valid,
    output logic [DATA_W-1:0]      pe_a,
    output logic [DATA_W-1:0]      pe_b,
    input  logic [ACC_W-1:0]       pe_y,
    input  logic                   pe_ovf,
    input  logic                   pe_done,
    output logic [ACC_W-1:0]       res,
    output logic                   res_ovf,
    output logic                   res_valid,
    output logic                   ovf_sticky,
    output logic                   finished,
    output logic                   timeout_err,
    output feeder_state_t          dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    feeder_state_t     r_state;
    logic [CW-1:0]     r_idx, r_count;
    logic [GAP_W-1:0]  r_gap, r_gcnt;
    logic [TW-1:0]     r_tcnt;
    logic [DATA_W-1:0] r_pe_a, r_pe_b;
    logic [ACC_W-1:0]  r_res;
    logic              r_res_ovf, r_res_valid, r_ovf_sticky;
    logic              r_finished, r_timeout_err, r_busy;

    logic [CW-1:0]     w_wr_ptr, w_eff_cnt, w_idx_inc;
    logic [AW-1:0]     w_rd_idx;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic              w_wait_state, w_wait_met, w_abort, w_zero_start, w_clear, w_wr_en;

    assign w_eff_cnt    = (count > w_wr_ptr) ? w_wr_ptr : count;
    assign w_idx_inc    = r_idx + 1'b1;
    assign w_rd_idx     = (r_state == S_GAP) ? w_idx_inc[AW-1:0] : '0;
    assign w_wr_en      = wr_en && (r_state == S_IDLE);
    assign w_zero_start = (r_state == S_IDLE) && start && (w_eff_cnt == '0);
    assign w_abort      = w_wait_state && !w_wait_met && (r_tcnt == T_MAX);
    assign w_clear      = w_abort || w_zero_start || (r_state == S_DONE);

    // ARM and WAIT_LO wait for done low, WAIT_HI for done high; all three share the timeout.
    always_comb begin
        w_wait_state = 1'b0;
        w_wait_met   = 1'b0;
        case (r_state)
            S_ARM, S_WAIT_LO: begin
                w_wait_state = 1'b1;
                w_wait_met   = !pe_done;
            end
            S_WAIT_HI: begin
                w_wait_state = 1'b1;
                w_wait_met   = pe_done;
            end
            default: ;
        endcase
    end

    pe_feeder_buf #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (w_wr_en),
        .i_wr_a   (wr_a),
        .i_wr_b   (wr_b),
        .i_clear  (w_clear),
        .i_rd_idx (w_rd_idx),
        .o_rd_a   (w_rd_a),
        .o_rd_b   (w_rd_b),
        .o_wr_ptr (w_wr_ptr),
        .o_full   (wr_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_count       <= '0;
            r_gap         <= '0;
            r_gcnt        <= '0;
            r_tcnt        <= '0;
            r_pe_a        <= '0;
            r_pe_b        <= '0;
            r_res         <= '0;
            r_res_ovf     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_ovf_sticky  <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_finished  <= 1'b0;
            r_tcnt      <= (w_wait_state && !w_wait_met) ? r_tcnt + 1'b1 : '0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_timeout_err <= 1'b0;
                    if (w_eff_cnt == '0) begin
                        r_finished <= 1'b1;
                    end else begin
                        r_state      <= S_ARM;
                        r_busy       <= 1'b1;
                        r_idx        <= '0;
                        r_count      <= w_eff_cnt;
                        r_gap        <= gap;
                        r_ovf_sticky <= 1'b0;
                    end
                end
                S_ARM: if (!pe_done) begin
                    r_state <= S_ISSUE;
                    r_pe_a  <= w_rd_a;
                    r_pe_b  <= w_rd_b;
                end
                S_ISSUE:   r_state <= S_WAIT_HI;
                S_WAIT_HI: if (pe_done) r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_res        <= pe_y;
                    r_res_ovf    <= pe_ovf;
                    r_ovf_sticky <= r_ovf_sticky | pe_ovf;
                    r_res_valid  <= 1'b1;
                    r_state      <= S_WAIT_LO;
                end
                S_WAIT_LO: if (!pe_done) begin
                    r_state <= S_GAP;
                    r_gcnt  <= r_gap;
                end
                S_GAP: begin
                    if (r_gcnt == '0) begin
                        r_idx <= w_idx_inc;
                        if (w_idx_inc == r_count) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                            r_pe_a  <= w_rd_a;
                            r_pe_b  <= w_rd_b;
                        end
                    end else begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_finished <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_abort) begin
                r_timeout_err <= 1'b1;
                r_finished    <= 1'b1;
                r_busy        <= 1'b0;
                r_state       <= S_IDLE;
            end
        end
    end

    assign pe_valid    = (r_state == S_ISSUE);
    assign pe_a        = r_pe_a;
    assign pe_b        = r_pe_b;
    assign res         = r_res;
    assign res_ovf     = r_res_ovf;
    assign res_valid   = r_res_valid;
    assign ovf_sticky  = r_ovf_sticky;
    assign finished    = r_finished;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: behavioural accumulating pe, operand/result scoreboards, directed sequences.
module tb_pe_feeder;
    import pe_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic              clk, reset, wr_en, wr_full, start, busy, pe_valid;
    logic [DATA_W-1:0] wr_a, wr_b, pe_a, pe_b;
    logic [3:0]        count;
    logic [7:0]        gap;
    logic [ACC_W-1:0]  pe_y, res;
    logic              pe_ovf, pe_done, res_ovf, res_valid, ovf_sticky, finished, timeout_err;
    feeder_state_t     dbg_state;

    pe_feeder #(.DEPTH(DEPTH), .GAP_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_full(wr_full),
        .start(start), .count(count), .gap(gap), .busy(busy), .pe_valid(pe_valid),
        .pe_a(pe_a), .pe_b(pe_b), .pe_y(pe_y), .pe_ovf(pe_ovf), .pe_done(pe_done),
        .res(res), .res_ovf(res_ovf), .res_valid(res_valid), .ovf_sticky(ovf_sticky),
        .finished(finished), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---- clock / reset ----
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- scoreboard state ----
    logic [ACC_W:0]      exp_q[$];   // {ovf, y}
    logic [2*DATA_W-1:0] op_q[$];    // {a, b}
    int n_checks = 0;
    int n_err    = 0;
    int n_pv = 0, n_rv = 0, n_fin = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        n_pv = 0;
        n_rv = 0;
        n_fin = 0;
    endtask

    // ---- behavioural pe: accumulates a*b, done high for two cycles, latency three ----
    int pe_mode = 0;          // 0 normal, 1 done stuck low, 2 done stuck high
    int pe_acc = 0, pe_t = 0, pe_cur = 0, pe_issue_n = 0, ovf_at = -1;
    bit pe_act = 0;

    task automatic pe_clear();
        pe_acc = 0;
        pe_act = 0;
        pe_issue_n = 0;
        pe_done = 1'b0;
    endtask

    initial begin
        pe_done = 1'b0;
        pe_y = '0;
        pe_ovf = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pe_mode == 2) pe_done = 1'b1;
            else if (pe_mode == 1) pe_done = 1'b0;
            else if (pe_act) begin
                pe_t++;
                if (pe_t == 3) begin
                    pe_done = 1'b1;
                    pe_y = pe_acc;
                    pe_ovf = (pe_cur == ovf_at);
                end
                if (pe_t == 5) begin
                    pe_done = 1'b0;
                    pe_act = 0;
                end
            end else pe_done = 1'b0;
            if (pe_valid) begin
                pe_acc = pe_acc + int'($signed(pe_a)) * int'($signed(pe_b));
                pe_cur = pe_issue_n;
                pe_issue_n++;
                pe_act = 1;
                pe_t = 0;
            end
        end
    end

    // ---- output monitor ----
    initial begin
        logic [ACC_W:0] e;
        logic [2*DATA_W-1:0] o;
        forever begin
            @(negedge clk);
            if (pe_valid) begin
                n_pv++;
                if (op_q.size() == 0) check("pe_valid_unexpected", 64'(pe_valid), 64'(0));
                else begin
                    o = op_q.pop_front();
                    check("pe_operands", 64'({pe_a, pe_b}), 64'(o));
                end
            end
            if (res_valid) begin
                n_rv++;
                if (exp_q.size() == 0) check("res_valid_unexpected", 64'(res_valid), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("res", 64'({res_ovf, res}), 64'(e));
                end
            end
            if (finished) n_fin++;
        end
    end

    // ---- driver tasks ----
    task automatic write_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        wr_en = 1'b1;
        wr_a = a;
        wr_b = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic start_seq(input logic [3:0] c, input logic [7:0] g);
        start = 1'b1;
        count = c;
        gap = g;
        step();
        start = 1'b0;
    endtask

    task automatic wait_finished(input string name, input int limit);
        int n = 0;
        while (!finished && n < limit) begin
            step();
            n++;
        end
        check(name, 64'(finished), 64'(1));
    endtask

    typedef struct {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic signed [ACC_W-1:0]  y;
    } vec_t;

    // ---- test sequence ----
    initial begin
        vec_t tbl[4];
        int acc_m;
        int n;
        logic signed [DATA_W-1:0] ra, rb;

        tbl[0] = '{8'sd10,  8'sd2,  32'sd20};
        tbl[1] = '{-8'sd20, 8'sd3,  -32'sd40};
        tbl[2] = '{8'sd30,  -8'sd4, -32'sd160};
        tbl[3] = '{-8'sd40, 8'sd5,  -32'sd360};

        reset = 1'b1; wr_en = 1'b0; wr_a = '0; wr_b = '0; start = 1'b0; count = '0; gap = '0;
        settle(3);
        check("reset_outputs", 64'({busy, pe_valid, pe_a, pe_b, res, res_ovf, res_valid,
                                    ovf_sticky, finished, timeout_err, wr_full}), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        step();

        // Four-pair accumulate from the table.
        clear_counts(); pe_clear();
        for (int i = 0; i < 4; i++) begin
            write_pair(tbl[i].a, tbl[i].b);
            op_q.push_back({tbl[i].a, tbl[i].b});
            exp_q.push_back({1'b0, tbl[i].y});
        end
        start_seq(4'd4, 8'd3);
        check("t1_arm_state", 64'(dbg_state), 64'(S_ARM));
        check("t1_busy", 64'(busy), 64'(1));
        step();
        check("t1_first_valid_latency", 64'(pe_valid), 64'(1));
        wait_finished("t1_finished", 300);
        check("t1_busy_end", 64'(busy), 64'(0));
        settle(3);
        check("t1_res_count", 64'(n_rv), 64'(4));
        check("t1_valid_count", 64'(n_pv), 64'(4));
        check("t1_fin_count", 64'(n_fin), 64'(1));
        check("t1_sticky", 64'(ovf_sticky), 64'(0));
        check("t1_queue_drained", 64'(exp_q.size()), 64'(0));

        // Overflow on the first pair only: captured per result and held sticky.
        clear_counts(); pe_clear(); ovf_at = 0;
        write_pair(8'sd3, 8'sd4); op_q.push_back({8'sd3, 8'sd4}); exp_q.push_back({1'b1, 32'sd12});
        write_pair(8'sd5, 8'sd6); op_q.push_back({8'sd5, 8'sd6}); exp_q.push_back({1'b0, 32'sd42});
        start_seq(4'd2, 8'd2);
        wait_finished("ovf_finished", 200);
        settle(2);
        check("ovf_sticky_set", 64'(ovf_sticky), 64'(1));
        check("ovf_res_count", 64'(n_rv), 64'(2));
        ovf_at = -1;

        // Nine writes into eight entries, count 9 clamps to 8.
        clear_counts(); pe_clear(); acc_m = 0;
        for (int i = 0; i < 9; i++) begin
            ra = DATA_W'($urandom_range(0, 255));
            rb = DATA_W'($urandom_range(0, 255));
            write_pair(ra, rb);
            if (i < DEPTH) begin
                acc_m = acc_m + int'(ra) * int'(rb);
                op_q.push_back({ra, rb});
                exp_q.push_back({1'b0, 32'(acc_m)});
            end
            check($sformatf("full_after_write%0d", i + 1), 64'(wr_full), 64'(i >= DEPTH - 1));
        end
        start_seq(4'd9, 8'd0);
        check("clamp_sticky_cleared", 64'(ovf_sticky), 64'(0));
        wait_finished("clamp_finished", 600);
        settle(2);
        check("clamp_valid_count", 64'(n_pv), 64'(8));
        check("clamp_res_count", 64'(n_rv), 64'(8));
        check("clamp_buffer_cleared", 64'(wr_full), 64'(0));

        // Empty buffer: finished next cycle, no issue.
        clear_counts(); pe_clear();
        start_seq(4'd4, 8'd0);
        check("empty_finished", 64'(finished), 64'(1));
        check("empty_busy", 64'(busy), 64'(0));
        step();
        check("empty_finished_pulse", 64'(finished), 64'(0));
        settle(4);
        check("empty_no_valid", 64'(n_pv), 64'(0));

        // count=0 with loaded buffer: also immediate, and the buffer is dropped.
        write_pair(8'sd1, 8'sd1);
        write_pair(8'sd2, 8'sd2);
        start_seq(4'd0, 8'd0);
        check("count0_finished", 64'(finished), 64'(1));
        check("count0_busy", 64'(busy), 64'(0));
        start_seq(4'd2, 8'd0);
        check("count0_buffer_cleared", 64'(finished), 64'(1));
        settle(4);
        check("count0_no_valid", 64'(n_pv), 64'(0));

        // Done stuck low: timeout abort after TIMEOUT+1 cycles in WAIT_HI.
        clear_counts(); pe_clear(); pe_mode = 1;
        write_pair(8'sd7, 8'sd9); op_q.push_back({8'sd7, 8'sd9});
        start_seq(4'd1, 8'd0);
        n = 0;
        while (dbg_state != S_WAIT_HI && n < 10) begin step(); n++; end
        check("to_reach_wait_hi", 64'(dbg_state), 64'(S_WAIT_HI));
        n = 0;
        while (dbg_state == S_WAIT_HI && n < 400) begin step(); n++; end
        check("to_cycles_in_wait_hi", 64'(n), 64'(TIMEOUT + 1));
        check("to_err", 64'(timeout_err), 64'(1));
        check("to_finished", 64'(finished), 64'(1));
        check("to_busy", 64'(busy), 64'(0));
        settle(3);
        check("to_no_result", 64'(n_rv), 64'(0));
        pe_mode = 0; pe_clear(); clear_counts();
        write_pair(8'sd6, -8'sd7); op_q.push_back({8'sd6, -8'sd7}); exp_q.push_back({1'b0, -32'sd42});
        start_seq(4'd1, 8'd1);
        check("to_err_cleared", 64'(timeout_err), 64'(0));
        wait_finished("to_recover_finished", 200);
        settle(2);
        check("to_recover_res", 64'(n_rv), 64'(1));

        // Stale done at start: no issue until done falls.
        clear_counts(); pe_clear(); pe_mode = 2;
        settle(2);
        write_pair(-8'sd8, -8'sd8); op_q.push_back({-8'sd8, -8'sd8}); exp_q.push_back({1'b0, 32'sd64});
        start_seq(4'd1, 8'd0);
        settle(10);
        check("stale_no_valid", 64'(n_pv), 64'(0));
        check("stale_in_arm", 64'(dbg_state), 64'(S_ARM));
        pe_mode = 0;
        wait_finished("stale_finished", 200);
        settle(2);
        check("stale_valid_count", 64'(n_pv), 64'(1));
        check("stale_res_count", 64'(n_rv), 64'(1));

        // Reset during WAIT_HI of pair 2.
        clear_counts(); pe_clear();
        for (int i = 0; i < 3; i++) begin
            write_pair(DATA_W'(i + 2), DATA_W'(5));
            op_q.push_back({DATA_W'(i + 2), 8'd5});
        end
        exp_q.push_back({1'b0, 32'sd10});
        exp_q.push_back({1'b0, 32'sd25});
        exp_q.push_back({1'b0, 32'sd45});
        start_seq(4'd3, 8'd1);
        n = 0;
        while ((n_pv < 2 || dbg_state != S_WAIT_HI) && n < 200) begin step(); n++; end
        check("rst_reached_pair2", 64'(dbg_state), 64'(S_WAIT_HI));
        reset = 1'b1;
        pe_clear();
        step();
        check("rst_mid_outputs", 64'({busy, pe_valid, pe_a, pe_b, res, res_ovf, res_valid,
                                      ovf_sticky, finished, timeout_err, wr_full}), 64'(0));
        check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        op_q.delete();
        exp_q.delete();
        step();
        n = n_pv;
        start_seq(4'd1, 8'd0);
        check("rst_after_finished", 64'(finished), 64'(1));
        check("rst_after_busy", 64'(busy), 64'(0));
        settle(4);
        check("rst_after_no_valid", 64'(n_pv), 64'(n));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
